// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer for one shared single-port synchronous memory
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_if_*, o_if_*                 instruction fetch requester (read-only)
//   i_ls_*, o_ls_*                 load/store requester (read or masked write)
//   o_mem_*, i_mem_rdata           memory macro command and read data
//   o_busy                         high while a transaction is in flight
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_ls_req,
    input  logic                i_ls_we,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [DATA_W/8-1:0] i_ls_bmask,
    output logic                o_ls_gnt,
    output logic                o_ls_rvalid,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;
    state_t                state;
    logic                  last_ls;
    logic                  win_ls;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   bmask_q;
    logic [2:0]            cnt;
    logic                  idle;
    logic [ADDR_W-1:0]     gnt_addr;
    // Gate with reset so no grant leaks out while reset is held with requests high
    assign idle        = i_rst_n && state == IDLE;
    // On a tie the requester that did not win last time gets the grant
    assign o_if_gnt    = idle && i_if_req && (!i_ls_req || last_ls);
    assign o_ls_gnt    = idle && i_ls_req && (!i_if_req || !last_ls);
    assign gnt_addr    = (o_ls_gnt ? i_ls_addr : i_if_addr) & ~ADDR_W'(3);
    assign o_mem_en    = state == CMD;
    assign o_mem_we    = o_mem_en && we_q;
    assign o_mem_addr  = o_mem_en ? addr_q : '0;
    assign o_mem_wdata = o_mem_en ? wdata_q : '0;
    assign o_mem_bmask = o_mem_en ? bmask_q : '0;
    assign o_if_rvalid = state == RESP && !win_ls;
    assign o_ls_rvalid = state == RESP && win_ls;
    assign o_busy      = state != IDLE;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_ls    <= 1'b0;
            win_ls     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bmask_q    <= '0;
            cnt        <= '0;
            o_if_rdata <= '0;
            o_ls_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (o_if_gnt || o_ls_gnt) begin
                    state   <= CMD;
                    win_ls  <= o_ls_gnt;
                    last_ls <= o_ls_gnt;
                    we_q    <= o_ls_gnt && i_ls_we;
                    addr_q  <= gnt_addr;
                    wdata_q <= o_ls_gnt ? i_ls_wdata : '0;
                    bmask_q <= o_ls_gnt ? i_ls_bmask : '0;
                end
                CMD: begin
                    cnt   <= 3'(MEM_LAT);
                    state <= WAIT;
                end
                // Count 1 marks the cycle whose closing edge carries the memory's read data
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= RESP;
                        if (win_ls)
                            o_ls_rdata <= we_q ? '0 : i_mem_rdata;
                        else
                            o_if_rdata <= i_mem_rdata;
                    end
                end
                RESP: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a random traffic model and a MEM_LAT=1 directed check
module tb_mem_arbiter;
    localparam int LAT = 2;
    typedef struct {
        bit          id;
        logic [31:0] data;
        int          due;
    } resp_t;
    typedef struct {
        int          due;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
    } cmd_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_bmask;
    logic        o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_mem_en, o_mem_we, o_busy;
    logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        b_rst_n, b_if_req, b_ls_req, b_ls_we;
    logic [31:0] b_if_addr, b_ls_addr, b_ls_wdata, b_mem_rdata;
    logic [3:0]  b_ls_bmask;
    logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_bmask;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          b_done = 1'b0;
    bit          if_g = 1'b0, ls_g = 1'b0;
    bit          m_last = 1'b0;
    int          m_start = 0, m_free = 0;
    logic [31:0] e_if = '0, e_ls = '0;
    resp_t       rq[$];
    cmd_t        cq[$];
    int          rd_due[$];
    logic [31:0] rd_val[$];
    logic [31:0] ref_mem[int];
    logic [31:0] phys_mem[int];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
        .i_ls_bmask(ls_bmask), .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask), .i_mem_rdata(mem_rdata),
        .o_busy(o_busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .i_clk(clk), .i_rst_n(b_rst_n),
        .i_if_req(b_if_req), .i_if_addr(b_if_addr), .o_if_gnt(b_if_gnt),
        .o_if_rvalid(b_if_rvalid), .o_if_rdata(b_if_rdata),
        .i_ls_req(b_ls_req), .i_ls_we(b_ls_we), .i_ls_addr(b_ls_addr), .i_ls_wdata(b_ls_wdata),
        .i_ls_bmask(b_ls_bmask), .o_ls_gnt(b_ls_gnt), .o_ls_rvalid(b_ls_rvalid), .o_ls_rdata(b_ls_rdata),
        .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .o_mem_bmask(b_mem_bmask), .i_mem_rdata(b_mem_rdata),
        .o_busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int k);
        return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] bm);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (bm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    function automatic logic [31:0] phys_rd(input int k);
        return phys_mem.exists(k) ? phys_mem[k] : init_word(k);
    endfunction

    // Memory macro model: stores land on the command cycle, read data appears LAT cycles later
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_due.delete();
            rd_val.delete();
        end else if (o_mem_en) begin
            if (o_mem_we)
                phys_mem[int'(o_mem_addr >> 2)] = merge(phys_rd(int'(o_mem_addr >> 2)), o_mem_wdata, o_mem_bmask);
            else begin
                rd_due.push_back(cyc + LAT);
                rd_val.push_back(phys_rd(int'(o_mem_addr >> 2)));
            end
        end
        if (rd_due.size() != 0 && rd_due[0] == cyc) begin
            mem_rdata = rd_val.pop_front();
            void'(rd_due.pop_front());
        end else
            mem_rdata = $urandom();
    end

    // Reference model and scoreboard monitor
    always @(negedge clk) begin
        bit    idle, exp_if, exp_ls, w;
        cmd_t  c;
        resp_t r;
        logic [31:0] a;
        if (!rst_n) begin
            chk("reset_outputs", 32'({o_if_gnt, o_if_rvalid, |o_if_rdata, o_ls_gnt, o_ls_rvalid, |o_ls_rdata,
                                      o_mem_en, o_mem_we, |o_mem_addr, |o_mem_wdata, |o_mem_bmask, o_busy}), 32'd0);
            rq.delete();
            cq.delete();
            m_last = 1'b0;
            m_start = 0;
            m_free = 0;
            e_if = '0;
            e_ls = '0;
            if_g = 1'b0;
            ls_g = 1'b0;
        end else begin
            idle   = cyc >= m_free;
            exp_if = idle && if_req && (!ls_req || m_last);
            exp_ls = idle && ls_req && (!if_req || !m_last);
            chk("if_gnt", 32'(o_if_gnt), 32'(exp_if));
            chk("ls_gnt", 32'(o_ls_gnt), 32'(exp_ls));
            chk("busy", 32'(o_busy), 32'(cyc >= m_start && cyc < m_free));
            if (cq.size() != 0 && cq[0].due == cyc) begin
                c = cq.pop_front();
                chk("mem_en", 32'(o_mem_en), 32'd1);
                chk("mem_we", 32'(o_mem_we), 32'(c.we));
                chk("mem_addr", o_mem_addr, c.addr);
                chk("mem_wdata", o_mem_wdata, c.wdata);
                chk("mem_bmask", 32'(o_mem_bmask), 32'(c.bmask));
                if (c.we) ref_mem[int'(c.addr >> 2)] = merge(ref_rd(int'(c.addr >> 2)), c.wdata, c.bmask);
            end else
                chk("mem_quiet", 32'({o_mem_en, o_mem_we, |o_mem_addr, |o_mem_wdata, |o_mem_bmask}), 32'd0);
            if (o_if_rvalid || o_ls_rvalid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_rvalid at cycle %0d: got if=%0b ls=%0b, expected none", cyc, o_if_rvalid, o_ls_rvalid);
                end else begin
                    r = rq.pop_front();
                    chk("rvalid_cycle", 32'(cyc), 32'(r.due));
                    chk("rvalid_id", 32'({o_if_rvalid, o_ls_rvalid}), r.id ? 32'd1 : 32'd2);
                    if (r.id) e_ls = r.data; else e_if = r.data;
                end
            end else if (rq.size() != 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_rvalid at cycle %0d: got none, expected id %0d", cyc, r.id);
            end
            chk("if_rdata", o_if_rdata, e_if);
            chk("ls_rdata", o_ls_rdata, e_ls);
            if (exp_if || exp_ls) begin
                w       = exp_ls;
                a       = (w ? ls_addr : if_addr) & ~32'd3;
                m_last  = w;
                m_start = cyc + 1;
                m_free  = cyc + 3 + LAT;
                cq.push_back('{due: cyc + 1, we: w && ls_we, addr: a,
                               wdata: w ? ls_wdata : 32'd0, bmask: w ? ls_bmask : 4'd0});
                rq.push_back('{id: w, data: (w && ls_we) ? 32'd0 : ref_rd(int'(a >> 2)), due: cyc + 2 + LAT});
            end
            if_g = o_if_gnt;
            ls_g = o_ls_gnt;
        end
    end

    // Requesters drop their request once the previous cycle showed a grant
    task automatic step();
        @(posedge clk);
        #1;
        if (if_req && if_g) if_req = 1'b0;
        if (ls_req && ls_g) ls_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {if_req, ls_req, ls_we} = '0;
        {if_addr, ls_addr, ls_wdata} = '0;
        ls_bmask = '0;
        mem_rdata = '0;
        phys_mem[32'h104 >> 2] = 32'h0050_0093;
        ref_mem[32'h104 >> 2]  = 32'h0050_0093;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // First tie after reset goes to LS, then fetch of 0x104
        if_req = 1'b1; if_addr = 32'h0000_0104;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20;
        repeat (12) step();
        // Full-word store to an unaligned address, then read it back
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_7003; ls_wdata = 32'hDEAD_BEEF; ls_bmask = 4'hF;
        repeat (8) step();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_7000;
        repeat (8) step();
        // Reset two cycles after a grant, with both requesters waiting through it
        ls_req = 1'b1; ls_addr = 32'h4;
        repeat (2) step();
        rst_n = 1'b0;
        if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h8; ls_addr = 32'hC;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (14) step();
        for (int k = 0; k < 3000; k++) begin
            step();
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req = 1'b1;
                if_addr = $urandom_range(0, 63);
            end else if (if_req && $urandom_range(0, 40) == 0)
                if_req = 1'b0;
            if (!ls_req && $urandom_range(0, 2) != 0) begin
                ls_req = 1'b1;
                ls_we = 1'($urandom_range(0, 1));
                ls_addr = $urandom_range(0, 63);
                ls_wdata = $urandom();
                ls_bmask = 4'($urandom_range(0, 15));
            end else if (ls_req && $urandom_range(0, 40) == 0)
                ls_req = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (LAT + 8) @(posedge clk);
        for (int i = 0; i < 100 && !b_done; i++) @(posedge clk);
        checks++;
        if (!b_done) begin
            errors++;
            $display("FAIL lat1_timeout: got unfinished, expected finished");
        end
        checks++;
        if (rq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding responses, expected 0", rq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // MEM_LAT=1 load: mem_en at T+1, data sampled at the end of T+2, rvalid at T+3
    initial begin
        b_rst_n = 1'b0;
        {b_if_req, b_ls_req, b_ls_we} = '0;
        {b_if_addr, b_ls_addr, b_ls_wdata} = '0;
        b_ls_bmask = '0;
        b_mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 b_rst_n = 1'b1;
        b_ls_req = 1'b1;
        b_ls_addr = 32'h20;
        @(negedge clk);
        chk("lat1_gnt", 32'(b_ls_gnt), 32'd1);
        @(posedge clk);
        #1 b_ls_req = 1'b0;
        @(negedge clk);
        chk("lat1_mem_en", 32'({b_mem_en, b_mem_we}), 32'd2);
        chk("lat1_mem_addr", b_mem_addr, 32'h20);
        b_mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("lat1_early_rvalid", 32'({b_ls_rvalid, b_if_rvalid}), 32'd0);
        b_mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("lat1_rvalid", 32'({b_ls_rvalid, b_if_rvalid}), 32'd2);
        chk("lat1_rdata", b_ls_rdata, 32'h1234_5678);
        b_mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("lat1_idle", 32'({b_busy, b_ls_rvalid}), 32'd0);
        chk("lat1_hold", b_ls_rdata, 32'h1234_5678);
        chk("lat1_if_rdata", b_if_rdata, 32'd0);
        b_done = 1'b1;
    end
endmodule
